// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S-family transmitter: mode encodings, FSM state type
// and the parameter legality check used at elaboration.
package i2s_pkg;

  localparam logic [1:0] MODE_I2S = 2'd0;
  localparam logic [1:0] MODE_LJ  = 2'd1;
  localparam logic [1:0] MODE_RJ  = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;

  function automatic bit params_ok(input int data_w, input int slot_w,
                                   input int clk_div, input int fifo_depth);
    return (data_w >= 1) && (data_w <= slot_w) &&
           (clk_div >= 2) && ((clk_div % 2) == 0) &&
           (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO holding stereo pairs; reset flushes the pointers, storage is not cleared.
module i2s_sample_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/i2s_frame_tx.sv
// Stereo I2S / left-justified / right-justified transmitter: buffers sample pairs and
// serialises them MSB-first with a clk-derived SCK, all logic on clk with SCK edge enables.
module i2s_frame_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              sck,
  output logic              ws,
  output logic              sd,
  output logic              frame_start,
  output logic              underflow,
  output i2s_state_e        dbg_state
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int PW      = $clog2(FRAME_W);
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(FRAME_W - 1);

  if (!params_ok(DATA_W, SLOT_W, CLK_DIV, FIFO_DEPTH)) begin : g_bad_params
    $error("i2s_frame_tx: illegal parameter combination");
  end

  // Stream handshake: a pair {s_left, s_right} is taken on a clk edge where
  // s_valid && s_ready; s_ready drops only while the FIFO holds FIFO_DEPTH pairs.
  logic [2*DATA_W-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty, fifo_pop;

  i2s_sample_fifo #(
    .W     (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s_valid),
    .wdata ({s_left, s_right}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  i2s_state_e          state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic [1:0]          mode_q, mode_d;
  logic [2*DATA_W-1:0] pair_q, pair_d;
  logic                sck_q, sck_d;
  logic                ws_q, ws_d;
  logic                sd_q, sd_d;
  logic                frame_start_q, frame_start_d;
  logic                underflow_q, underflow_d;
  logic                bit_ev;
  logic [PW-1:0]       next_pos;

  function automatic logic ws_for(input logic [PW-1:0] p, input logic [1:0] m);
    int pi;
    pi = int'(p);
    if (m == MODE_LJ || m == MODE_RJ) return (pi >= SLOT_W);
    return (pi >= SLOT_W - 1) && (pi < FRAME_W - 1);
  endfunction

  function automatic logic sd_for(input logic [PW-1:0] p, input logic [1:0] m,
                                  input logic [2*DATA_W-1:0] pair);
    int pi;
    int b;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] sh;
    logic bit_v;
    pi    = int'(p);
    b     = (pi >= SLOT_W) ? pi - SLOT_W : pi;
    word  = (pi < SLOT_W) ? pair[2*DATA_W-1:DATA_W] : pair[DATA_W-1:0];
    bit_v = 1'b0;
    sh    = '0;
    // RJ places the LSB in the last slot bit; I2S/LJ (and reserved mode) start at bit 0.
    if (m == MODE_RJ) begin
      if (b >= SLOT_W - DATA_W) begin
        sh    = word >> (SLOT_W - 1 - b);
        bit_v = sh[0];
      end
    end else if (b < DATA_W) begin
      sh    = word >> (DATA_W - 1 - b);
      bit_v = sh[0];
    end
    return bit_v;
  endfunction

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    pos_d         = pos_q;
    mode_d        = mode_q;
    pair_d        = pair_q;
    sck_d         = sck_q;
    ws_d          = ws_q;
    sd_d          = sd_q;
    frame_start_d = 1'b0;
    underflow_d   = 1'b0;
    fifo_pop      = 1'b0;
    bit_ev        = 1'b0;
    next_pos      = pos_q;

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        pos_d = '0;
        sck_d = 1'b0;
        ws_d  = 1'b0;
        sd_d  = 1'b0;
        // The start cycle acts as a virtual SCK falling edge driving bit 0.
        if (enable) begin
          state_d  = ST_RUN;
          bit_ev   = 1'b1;
          next_pos = '0;
        end
      end
      ST_RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = 1'b0;
          if (pos_q == POS_LAST && !enable) begin
            state_d = ST_IDLE;
            pos_d   = '0;
            ws_d    = 1'b0;
            sd_d    = 1'b0;
          end else begin
            bit_ev   = 1'b1;
            next_pos = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
          if (div_q == DIV_RISE) sck_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bit_ev) begin
      pos_d = next_pos;
      if (next_pos == '0) begin
        frame_start_d = 1'b1;
        mode_d        = mode;
        fifo_pop      = !fifo_empty;
        underflow_d   = fifo_empty;
        pair_d        = fifo_empty ? '0 : fifo_rdata;
      end
      ws_d = ws_for(next_pos, mode_d);
      sd_d = sd_for(next_pos, mode_d, pair_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      pos_q         <= '0;
      mode_q        <= MODE_I2S;
      pair_q        <= '0;
      sck_q         <= 1'b0;
      ws_q          <= 1'b0;
      sd_q          <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      pos_q         <= pos_d;
      mode_q        <= mode_d;
      pair_q        <= pair_d;
      sck_q         <= sck_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign s_ready     = !fifo_full;
  assign sck         = sck_q;
  assign ws          = ws_q;
  assign sd          = sd_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
  assign dbg_state   = state_q;

endmodule
